gate_share_sched: RTL and testbench
===================================

# gate_share_sched

Round-robin scheduler that time-shares one quad 2-input AND package (74x08 model) among `N_REQ` requesters. Each requester presents a 4-bit A/B operand pair with a request line. The scheduler grants one requester at a time, drives the shared gate from registered operands, and returns the registered result tagged with the winner's index. It sits between requester logic and a single `MOD_74x08` instance, so several datapaths can use one gate package.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 1..16.
- `WIDTH`, 4: gate bits per transaction; fixed to the package gate count.

Ports (clock and reset first):
- `CLK`  in  1  — single clock; all state changes on the rising edge.
- `RST_N`  in  1  — reset is synchronous and active-low.
- `REQ`  in  N_REQ  — request line per requester, level.
- `A`  in  N_REQ*WIDTH  — operand A; slice i belongs to requester i.
- `B`  in  N_REQ*WIDTH  — operand B; slice i belongs to requester i.
- `GNT`  out  N_REQ  — one-hot grant, registered, single-cycle pulse.
- `Y`  out  WIDTH  — registered AND result.
- `Y_VLD`  out  1  — `Y` and `Y_ID` valid, single-cycle pulse.
- `Y_ID`  out  IDW  — index of the result's requester, IDW = max(1, clog2(N_REQ)).
- `BUSY`  out  1  — high whenever the FSM is not in IDLE.
- `GNT_CNT`  out  N_REQ*8  — per-requester grant counters (see Configuration).

## Operation
- FSM states: IDLE, EVAL, DONE.
- IDLE with `REQ`==0: stays in IDLE.
- IDLE with `REQ`!=0: picks the winner w.
  - w is the first set `REQ` bit found searching upward from pointer `ptr`, wrapping past N_REQ-1 to 0.
  - Latches A[w], B[w] into the operand registers.
  - Sets `GNT` to onehot(w) and the id register to w.
  - Moves to EVAL.
- EVAL:
  - Shared gate output (operand regA & regB) is captured into `Y`.
  - `Y_VLD`<=1, `Y_ID`<=w, `GNT`<=0.
  - Moves to DONE.
- DONE:
  - `Y_VLD`<=0.
  - `ptr`<=w+1, wrapping N_REQ-1 to 0.
  - Moves to IDLE.
- Handshake: a requester holds `REQ` and its operands stable until it sees its `GNT` bit.
  - After `GNT`, operands are don't-care.
  - Dropping `REQ` after the grant does not cancel the transaction.
  - A `REQ` dropped before it is granted is simply not considered.
- A requester still holding `REQ` after its own DONE is eligible again. It is served only after the other pending requesters, because `ptr` has moved past it.
- Simultaneous requests: exactly one grant per transaction. There is no starvation: worst-case wait is (N_REQ-1) transactions.
- `Y` holds its last value until the next EVAL capture.
- Reset values: all outputs 0, state IDLE, `ptr`=0, operand registers 0, counters 0.
- Reset asserted mid-transaction aborts it. No `Y_VLD` is produced and the result is discarded.

## Timing
- Edge k in IDLE with a request → `GNT` high during cycle k+1.
- Edge k+1 → `Y_VLD` and `Y` valid during cycle k+2.
- Edge k+2 → back in IDLE.
- The next grant is taken at edge k+3; `GNT` is high again in cycle k+4.
- Throughput: one transaction per 3 cycles. Latency from REQ sample to `Y_VLD` = 2 edges.
- `BUSY` is high during cycles k+1 and k+2.
- `REQ` changes during EVAL or DONE are ignored until IDLE.

## Configuration
- `GATE_SCHED_STATS_EN` defined:
  - `GNT_CNT` slice i is an 8-bit counter incremented on each grant to requester i.
  - The counter saturates at 255 and does not wrap.
  - It clears only on reset.
- Not defined: `GNT_CNT` is tied to 0 and no counter flops exist. Port list is unchanged.

## Structure
- Shared package `gate_sched_pkg`:
  - State encoding constants: IDLE=2'd0, EVAL=2'd1, DONE=2'd2.
  - `WIDTH`=4.
  - Counter width 8 and saturation value 255.
- One sub-module, `rr_pick`: combinational round-robin search taking `REQ` and `ptr`, returning winner index and an any-request flag.
- The scheduler instantiates `rr_pick` and the existing `MOD_74x08` model for the gate.

## Test plan
- Single requester: N_REQ=4, REQ=4'b0010, A1=4'b1100, B1=4'b1010.
  - Required: GNT=4'b0010 for 1 cycle.
  - Required: next cycle Y=4'b1000, Y_VLD=1, Y_ID=1.
- All request continuously, A=B=4'b1111 for every requester.
  - Required: grant order 0,1,2,3,0, one grant every 3 cycles.
  - Required: every result Y=4'b1111.
- Fairness: REQ held at 4'b1001 over 4 transactions.
  - Required: grant order 0,3,0,3.
- Withdrawal: REQ2 drops one cycle after GNT[2].
  - Required: Y_VLD still fires with Y_ID=2.
  - Required: Y=A2&B2, using the latched values even though the inputs changed to 0.
- Reset mid-transaction: RST_N=0 during the EVAL cycle.
  - Required: no Y_VLD; all outputs 0; the next request from requester 3 wins with ptr=0 search, so Y_ID=3.
- With `GATE_SCHED_STATS_EN`: 300 grants to requester 0 → GNT_CNT[7:0]=255.
  - Without the macro: GNT_CNT stays 0.

Source files
------------

// File: rtl/gate_sched_pkg.sv
// Shared constants for the gate_share_sched round-robin gate scheduler.
package gate_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam int         WIDTH   = 4;
    localparam int         CNT_W   = 8;
    localparam logic [7:0] CNT_MAX = 8'd255;

endpackage

// File: rtl/MOD_74x08.sv
// Behavioural model of a 74x08 quad 2-input AND package.
module MOD_74x08 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Y
);

    assign Y = A & B;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [IDW-1:0]   win_o,
    output logic             any_o
);

    logic found;
    int   idx;

    always_comb begin
        found = 1'b0;
        idx   = 0;
        win_o = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(ptr_i) + off) % N_REQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win_o = IDW'(idx);
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/gate_share_sched.sv
// Time-shares one MOD_74x08 among N_REQ requesters (IDLE/EVAL/DONE, 3 cycles each).
// Define GATE_SCHED_STATS_EN to build saturating per-requester grant counters.
module gate_share_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = gate_sched_pkg::WIDTH,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] A,
    input  logic [N_REQ*WIDTH-1:0] B,
    output logic [N_REQ-1:0]       GNT,
    output logic [WIDTH-1:0]       Y,
    output logic                   Y_VLD,
    output logic [IDW-1:0]         Y_ID,
    output logic                   BUSY,
    output logic [N_REQ*8-1:0]     GNT_CNT
);

    import gate_sched_pkg::*;

    sched_state_t     state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_vld_q, y_vld_d;
    logic [IDW-1:0]   y_id_q, y_id_d;

    logic [IDW-1:0]   win;
    logic             any_req;
    logic [WIDTH-1:0] gate_y;

    rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
        .req_i (REQ),
        .ptr_i (ptr_q),
        .win_o (win),
        .any_o (any_req)
    );

    MOD_74x08 u_gate (
        .A (opa_q),
        .B (opb_q),
        .Y (gate_y)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            gnt_q   <= '0;
            y_q     <= '0;
            y_vld_q <= 1'b0;
            y_id_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
            y_id_q  <= y_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        gnt_d   = gnt_q;
        y_d     = y_q;
        y_vld_d = y_vld_q;
        y_id_d  = y_id_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = EVAL;
                    id_d       = win;
                    opa_d      = A[int'(win)*WIDTH +: WIDTH];
                    opb_d      = B[int'(win)*WIDTH +: WIDTH];
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                end
            end
            EVAL: begin
                state_d = DONE;
                y_d     = gate_y;
                y_vld_d = 1'b1;
                y_id_d  = id_q;
                gnt_d   = '0;
            end
            DONE: begin
                state_d = IDLE;
                y_vld_d = 1'b0;
                // Moving past the winner is what makes the next search fair.
                ptr_d   = (int'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign GNT   = gnt_q;
    assign Y     = y_q;
    assign Y_VLD = y_vld_q;
    assign Y_ID  = y_id_q;
    assign BUSY  = (state_q != IDLE);

`ifdef GATE_SCHED_STATS_EN
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                cnt_q <= '0;
            end else if ((state_q == IDLE) && gnt_d[gi] && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign GNT_CNT[gi*8 +: 8] = cnt_q;
    end
`else
    assign GNT_CNT = '0;
`endif

endmodule

// File: tb/tb_gate_share_sched.sv
// Directed bench for gate_share_sched: vector table plus multi-cycle corner sequences.
module tb_gate_share_sched;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  REQ;
    logic [15:0] A, B;
    logic [3:0]  GNT;
    logic [3:0]  Y;
    logic        Y_VLD;
    logic [1:0]  Y_ID;
    logic        BUSY;
    logic [31:0] GNT_CNT;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  gnt;
        logic [3:0]  y;
        logic [1:0]  id;
    } vec_t;

    vec_t vecs [7];

    gate_share_sched #(.N_REQ(4), .WIDTH(4)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ     (REQ),
        .A       (A),
        .B       (B),
        .GNT     (GNT),
        .Y       (Y),
        .Y_VLD   (Y_VLD),
        .Y_ID    (Y_ID),
        .BUSY    (BUSY),
        .GNT_CNT (GNT_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_gnt(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            if (GNT != 4'd0) ok = 1'b1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s: no grant within 10 cycles", name);
        end
    endtask

    task automatic do_txn(input string name, input logic [3:0] req, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] eg, input logic [3:0] ey,
                          input logic [1:0] eid);
        bit ok;
        REQ = req;
        A   = a;
        B   = b;
        wait_gnt(name, ok);
        if (ok) begin
            REQ = '0;
            A   = '0;
            B   = '0;
            chk({name, " gnt"}, 32'(GNT), 32'(eg));
            chk({name, " busy_eval"}, 32'(BUSY), 32'd1);
            step();
            chk({name, " y_vld"}, 32'(Y_VLD), 32'd1);
            chk({name, " y"}, 32'(Y), 32'(ey));
            chk({name, " y_id"}, 32'(Y_ID), 32'(eid));
            chk({name, " gnt_clear"}, 32'(GNT), 32'd0);
            step();
            chk({name, " y_vld_drop"}, 32'(Y_VLD), 32'd0);
            chk({name, " busy_idle"}, 32'(BUSY), 32'd0);
            $display("[TB] %s req=%b gnt=%b y=%b id=%0d", name, req, eg, ey, eid);
        end
    endtask

    // Holds REQ steady and follows back-to-back grants, 3 cycles apart.
    task automatic run_stream(input string name, input logic [3:0] req, input logic [15:0] a,
                              input logic [15:0] b, input int n,
                              input logic [1:0] order [5], input logic [3:0] ys [5]);
        bit ok;
        REQ = req;
        A   = a;
        B   = b;
        wait_gnt(name, ok);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s gnt%0d", name, i), 32'(GNT), 32'(4'd1 << order[i]));
                if (i == n - 1) REQ = '0;
                step();
                chk($sformatf("%s y_vld%0d", name, i), 32'(Y_VLD), 32'd1);
                chk($sformatf("%s y%0d", name, i), 32'(Y), 32'(ys[i]));
                chk($sformatf("%s id%0d", name, i), 32'(Y_ID), 32'(order[i]));
                $display("[TB] %s grant %0d id=%0d y=%b", name, i, Y_ID, Y);
                step();
                step();
            end
            chk({name, " idle_after"}, 32'(GNT), 32'd0);
        end
    endtask

    initial begin
        logic [1:0] ord [5];
        logic [3:0] ys  [5];
        bit         ok;
        int         ngnt;

        vecs[0] = '{4'b0010, 16'hFFCF, 16'h55A5, 4'b0010, 4'b1000, 2'd1};
        vecs[1] = '{4'b0001, 16'h3336, 16'hCCC3, 4'b0001, 4'b0010, 2'd0};
        vecs[2] = '{4'b1100, 16'h9F00, 16'hB5FF, 4'b0100, 4'b0101, 2'd2};
        vecs[3] = '{4'b1100, 16'h9F00, 16'hB5FF, 4'b1000, 4'b1001, 2'd3};
        vecs[4] = '{4'b1111, 16'h111A, 16'hFFFF, 4'b0001, 4'b1010, 2'd0};
        vecs[5] = '{4'b0001, 16'hFFF0, 16'hFFFF, 4'b0001, 4'b0000, 2'd0};
        vecs[6] = '{4'b1000, 16'h7000, 16'hE000, 4'b1000, 4'b0110, 2'd3};

        RST_N = 1'b0;
        REQ   = '0;
        A     = '0;
        B     = '0;
        repeat (3) step();
        chk("rst gnt", 32'(GNT), 32'd0);
        chk("rst y", 32'(Y), 32'd0);
        chk("rst y_vld", 32'(Y_VLD), 32'd0);
        chk("rst y_id", 32'(Y_ID), 32'd0);
        chk("rst busy", 32'(BUSY), 32'd0);
        chk("rst cnt", GNT_CNT, 32'd0);
        RST_N = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].a, vecs[i].b,
                   vecs[i].gnt, vecs[i].y, vecs[i].id);
        end

        // All requesting from ptr=0: order 0,1,2,3,0.
        ord = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        ys  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        run_stream("all_req", 4'b1111, 16'hFFFF, 16'hFFFF, 5, ord, ys);

        // ptr is 1 here; park it at 0 before the fairness run.
        do_txn("park", 4'b1000, 16'h5000, 16'h3000, 4'b1000, 4'b0001, 2'd3);
        ord = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0};
        ys  = '{4'h3, 4'hC, 4'h3, 4'hC, 4'h0};
        run_stream("fair", 4'b1001, 16'hC003, 16'hFFFF, 4, ord, ys);

        do_txn("withdraw", 4'b0100, 16'h0D00, 16'h0700, 4'b0100, 4'b0101, 2'd2);

        // Reset lands on the EVAL edge; ptr is 3 before it.
        REQ = 4'b0001;
        A   = 16'h000F;
        B   = 16'h000F;
        wait_gnt("midrst", ok);
        chk("midrst gnt", 32'(GNT), 32'd1);
        REQ   = '0;
        RST_N = 1'b0;
        step();
        chk("midrst y_vld", 32'(Y_VLD), 32'd0);
        chk("midrst gnt0", 32'(GNT), 32'd0);
        chk("midrst y", 32'(Y), 32'd0);
        chk("midrst y_id", 32'(Y_ID), 32'd0);
        chk("midrst busy", 32'(BUSY), 32'd0);
        chk("midrst cnt", GNT_CNT, 32'd0);
        RST_N = 1'b1;
        step();
        chk("midrst y_vld_after", 32'(Y_VLD), 32'd0);
        $display("[TB] midrst aborted");
        do_txn("post_rst1", 4'b1010, 16'h6090, 16'hF0F0, 4'b0010, 4'b1001, 2'd1);
        do_txn("post_rst3", 4'b1000, 16'h6090, 16'hF0F0, 4'b1000, 4'b0110, 2'd3);

`ifdef GATE_SCHED_STATS_EN
        REQ  = 4'b0001;
        A    = '0;
        B    = '0;
        ngnt = 0;
        for (int c = 0; c < 1500 && ngnt < 300; c++) begin
            step();
            if (GNT[0]) ngnt++;
        end
        REQ = '0;
        repeat (4) step();
        chk("stats grants", 32'(ngnt), 32'd300);
        chk("stats cnt0", 32'(GNT_CNT[7:0]), 32'd255);
        chk("stats cnt1", 32'(GNT_CNT[15:8]), 32'd1);
        chk("stats cnt3", 32'(GNT_CNT[31:24]), 32'd1);
        $display("[TB] stats cnt=%h", GNT_CNT);
`else
        ngnt = 0;
        chk("nostats cnt", GNT_CNT, 32'(ngnt));
        $display("[TB] nostats cnt=%h", GNT_CNT);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
